// File: rtl/uart_pkg.sv
// Shared UART constants and state encoding, used by both the transmit and receive paths.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 27;
  localparam int UART_DATA_BITS       = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts clocks while enabled and flags the last clock of each bit.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 27
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic enable,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count up while enabled, wrapping at the bit boundary; park at zero when disabled.
  always_comb begin
    cnt_d = '0;
    if (enable) begin
      if (cnt_q == LAST) cnt_d = '0;
      else               cnt_d = cnt_q + 1'b1;
    end
  end

  assign bit_end = enable && (cnt_q == LAST);

  // Counter register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_transmit.sv
// 8N1 UART transmitter with a one-byte holding register for gapless back-to-back frames.
module uart_transmit
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int STOP_BITS    = 1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [UART_DATA_BITS-1:0] DATA,
  input  logic                      DATA_VALID,
  output logic                      TXD_READY,
  output logic                      TXD,
  output logic                      BUSY
);

  localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e               state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] hold_q, hold_d;
  logic                      hold_full_q, hold_full_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic                      stop_cnt_q, stop_cnt_d;
  logic                      txd_q, txd_d;
  logic                      accept;
  logic                      bit_end;

  assign accept = DATA_VALID && !hold_full_q;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .enable (state_q != ST_IDLE),
    .bit_end(bit_end)
  );

  // Next-state, datapath and line-level logic; TXD is derived from the next state so it is a pure flop output.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_idx_d   = bit_idx_q;
    stop_cnt_d  = stop_cnt_q;
    txd_d       = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_d = DATA;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_BIT) begin
            stop_cnt_d = 1'b0;
            state_d    = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_cnt_q == LAST_STOP) begin
            if (hold_full_q) begin
              shift_d     = hold_q;
              hold_full_d = 1'b0;
              state_d     = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept && (state_q != ST_IDLE)) begin
      hold_d      = DATA;
      hold_full_d = 1'b1;
    end

    case (state_d)
      ST_IDLE:  txd_d = 1'b1;
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[bit_idx_d];
      ST_STOP:  txd_d = 1'b1;
      default:  txd_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame and drops a queued byte.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_idx_q   <= 3'd0;
      stop_cnt_q  <= 1'b0;
      txd_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_idx_q   <= bit_idx_d;
      stop_cnt_q  <= stop_cnt_d;
      txd_q       <= txd_d;
    end
  end

  assign TXD       = txd_q;
  assign TXD_READY = !hold_full_q;
  assign BUSY      = (state_q != ST_IDLE);

endmodule

// File: doc/uart_transmit.md
# uart_transmit

Serial UART transmitter, the sending counterpart of `uart_receive`. It takes bytes from fabric logic over a valid/ready handshake and drives them on `TXD` as 8N1 frames: start bit 0, eight data bits LSB-first, stop bit 1. A one-entry holding register lets a producer queue the next byte while the current frame shifts out, so back-to-back frames have no idle gap. Default timing is 27 MHz CLK at 1 Mbaud, giving 27 clocks per bit, the same as the receive path.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 27: clock cycles per serial bit. Must be ≥ 2.
- `STOP_BITS`, default 1: number of stop bits. Legal values are 1 or 2.

Ports:
- `CLK`  in  1: system clock. All logic uses the rising edge.
- `RST_N`  in  1: reset, synchronous and active-low.
- `DATA`  in  8: byte to send. Sampled only on accept.
- `DATA_VALID`  in  1: producer has a byte on `DATA`.
- `TXD_READY`  out  1: holding register is empty, so a byte can be accepted.
- `TXD`  out  1: serial line. Idles high.
- `BUSY`  out  1: a frame is being shifted out (state is not IDLE).

## Operation
- Accept happens on a rising edge where `DATA_VALID && TXD_READY`. If `DATA_VALID` is high while `TXD_READY` is low, the byte is ignored and not latched. The producer holds the byte until accepted.
- Where an accepted byte goes:
  - If state is IDLE, it loads the shifter directly and the hold register is unused.
  - Otherwise it loads the hold register.
- `TXD_READY` is the inverse of the hold register's full flag.
- State machine:
  - IDLE: `TXD` = 1. On accept, go to START.
  - START: `TXD` = 0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `TXD` = shifter[bit index] for `CLKS_PER_BIT` cycles per bit. Bit index runs 0 to 7, then go to STOP.
  - STOP: `TXD` = 1 for `STOP_BITS`×`CLKS_PER_BIT` cycles. At the end:
    - If hold is full, move hold into the shifter, clear hold, and go to START.
    - Otherwise go to IDLE.
- Baud counter:
  - Width is $clog2(`CLKS_PER_BIT`).
  - Counts 0 to `CLKS_PER_BIT`−1 and wraps to 0 on each bit boundary.
  - Held at 0 in IDLE.
- Reset (`RST_N` = 0 at a rising edge) applies to all registers:
  - state = IDLE, counters = 0, hold empty.
  - `TXD` = 1, `TXD_READY` = 1, `BUSY` = 0.
- Reset mid-frame aborts the frame: `TXD` returns high on the next edge and the queued byte is discarded. No partial recovery.

## Timing
- All outputs are registered or decoded from registers only. There is no combinational path from `DATA_VALID` to any output.
- Latency from an accept in IDLE at edge k:
  - `TXD` goes 0 and `BUSY` goes 1 from edge k.
  - `TXD_READY` stays 1, because the hold register is still empty.
- Frame length is (10 + `STOP_BITS` − 1)×`CLKS_PER_BIT` cycles, which is 270 at the defaults. Every bit lasts exactly `CLKS_PER_BIT` cycles, with no jitter.
- Back-to-back frames: the next start bit begins on the edge that ends the last stop-bit cycle. At that same edge `TXD_READY` rises. `BUSY` stays 1 throughout.
- No accept is possible in the cycle the hold register drains, because `TXD_READY` is still 0 then. A new byte can be accepted from the following edge.
- `BUSY` falls on the edge that returns the state machine to IDLE.
- `TXD` is glitch-free: it is driven straight from a flop.

## Structure
- Shared package `uart_pkg`:
  - `CLKS_PER_BIT_DEFAULT` = 27.
  - `UART_DATA_BITS` = 8.
  - State enum IDLE/START/DATA/STOP.
  - The same constants are consumed by `uart_receive`.
- One natural sub-module: `uart_baud_counter`.
  - Parameterised by `CLKS_PER_BIT`.
  - Inputs: `CLK`, `RST_N`, enable.
  - Output: a one-cycle bit-end strobe.
  - Available for reuse in the receiver.
- Remaining logic (FSM, shifter, hold register, bit index) stays in `uart_transmit`.

## Test plan
All scenarios use the default parameters: 27-cycle bits, 37.04 ns clock.
- **Single byte:** reset, then send 0x55 with one accept. Required:
  - `TXD` sequence 0,1,0,1,0,1,0,1,0,1, each bit exactly 27 cycles.
  - `BUSY` high for 270 cycles, then `TXD` = 1.
- **Back-to-back:** send 0xAA, then hold 0x0F valid until accepted. Required:
  - The second start bit begins exactly 270 cycles after the first.
  - There is no high gap between the stop bit and the next start bit.
  - `TXD_READY` low from the second accept until edge 270.
- **Ignored valid:** while the hold register is full, pulse `DATA_VALID` with 0xFF. Required: no third frame, and the hold contents are unchanged.
- **Reset mid-frame:** start 0x33, then assert `RST_N` = 0 at cycle 100 of the frame. Required:
  - `TXD` = 1, `TXD_READY` = 1, `BUSY` = 0 from the next edge.
  - A later byte 0x81 is transmitted correctly.
- **Loopback:** connect `TXD` to `uart_receive` `RXD` and send 0x00, 0xFF, 0xA5, 0x5A back-to-back. Required: four `RXD_READY` pulses, with `DATA` matching each byte in order.
- **Parameter sweep:** run with `CLKS_PER_BIT` = 2 and `STOP_BITS` = 2. Required:
  - Frame length is 22 cycles.
  - The stop level lasts 4 cycles.
